// File: rtl/debugger_protocol_pkg.sv
// Shared protocol constants and state encoding for the
// debugger value-bank command engine and its users.
package debugger_protocol_pkg;

  localparam logic [7:0] OPCODE_WRITE = 8'h01;
  localparam logic [7:0] OPCODE_READ  = 8'h02;
  localparam logic [7:0] RESP_ERROR   = 8'hEE;

  localparam logic [15:0] VALUEID_NES_RESET_N         = 16'd1;
  localparam logic [15:0] VALUEID_DEBUGGER_MEMORY_POOL = 16'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID_HI,
    S_ID_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_ACCESS,
    S_RESP_OP,
    S_RESP_HI,
    S_RESP_LO,
    S_RESP_ERR
  } state_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OPCODE_WRITE) || (b == OPCODE_READ);
  endfunction

endpackage

// File: rtl/debugger_value_initiator_if.sv
// Response byte stream from the command engine to the
// debugger transmitter, valid/ready handshake.
interface debugger_value_initiator_if;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/debugger_byte_timeout.sv
// Inter-byte idle counter; fires once when the gap
// between bytes of a command reaches the limit.
module debugger_byte_timeout #(
  parameter int P_TIMEOUT_CYCLES = 1000000,
  parameter int P_TIMEOUT_WIDTH  = 20
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [P_TIMEOUT_WIDTH-1:0] LIMIT =
    P_TIMEOUT_WIDTH'(P_TIMEOUT_CYCLES);

  logic [P_TIMEOUT_WIDTH-1:0] cnt_q;
  logic [P_TIMEOUT_WIDTH-1:0] cnt_d;

  // Count while enabled, restart on a byte or when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || !i_en) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A byte in the same cycle takes precedence.
  assign o_expired = i_en && !i_clr && (cnt_q == LIMIT);

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debugger_value_initiator.sv
// Parses debugger rx bytes into value-bank accesses and
// streams the echo/read-data response back out.
module debugger_value_initiator
  import debugger_protocol_pkg::*;
#(
  parameter int P_TIMEOUT_CYCLES = 1000000,
  parameter int P_TIMEOUT_WIDTH  = 20
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_rx_valid,
  input  logic [7:0]                 i_rx_data,
  debugger_value_initiator_if.master tx,
  output logic                       o_ena,
  output logic                       o_wea,
  output logic [15:0]                o_id,
  output logic [15:0]                o_data,
  input  logic [15:0]                i_data,
  output logic                       o_busy,
  output logic                       o_overrun
);

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] id_q, id_d;
  logic [15:0] data_q, data_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ena_q, ena_d;
  logic        wea_q, wea_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic in_cmd;
  logic in_resp;
  logic tx_fire;
  logic expired;
  logic is_wr;

  assign in_cmd = (state_q == S_ID_HI) ||
                  (state_q == S_ID_LO) ||
                  (state_q == S_DATA_HI) ||
                  (state_q == S_DATA_LO);

  assign in_resp = (state_q == S_ACCESS) ||
                   (state_q == S_RESP_OP) ||
                   (state_q == S_RESP_HI) ||
                   (state_q == S_RESP_LO) ||
                   (state_q == S_RESP_ERR);

  assign tx_fire = tx_valid_q && tx.tx_ready;
  assign is_wr   = (op_q == OPCODE_WRITE);

  debugger_byte_timeout #(
    .P_TIMEOUT_CYCLES(P_TIMEOUT_CYCLES),
    .P_TIMEOUT_WIDTH (P_TIMEOUT_WIDTH)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clr    (i_rx_valid),
    .i_en     (in_cmd),
    .o_expired(expired)
  );

  // Next-state, field capture and response sequencing.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    id_d       = id_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    ena_d      = 1'b0;
    wea_d      = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    overrun_d  = i_rx_valid && in_resp;

    unique case (state_q)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (is_opcode(i_rx_data)) begin
            op_d    = i_rx_data;
            state_d = S_ID_HI;
          end else begin
            state_d    = S_RESP_ERR;
            tx_valid_d = 1'b1;
            tx_data_d  = RESP_ERROR;
          end
        end
      end
      S_ID_HI: begin
        if (i_rx_valid) begin
          id_d[15:8] = i_rx_data;
          state_d    = S_ID_LO;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_ID_LO: begin
        if (i_rx_valid) begin
          id_d[7:0] = i_rx_data;
          if (is_wr) begin
            state_d = S_DATA_HI;
          end else begin
            state_d = S_ACCESS;
            ena_d   = 1'b1;
          end
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_DATA_HI: begin
        if (i_rx_valid) begin
          data_d[15:8] = i_rx_data;
          state_d      = S_DATA_LO;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_DATA_LO: begin
        if (i_rx_valid) begin
          data_d[7:0] = i_rx_data;
          state_d     = S_ACCESS;
          ena_d       = 1'b1;
          wea_d       = 1'b1;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (!is_wr) begin
          rdata_d = i_data;
        end
        state_d    = S_RESP_OP;
        tx_valid_d = 1'b1;
        tx_data_d  = op_q;
      end
      S_RESP_OP: begin
        if (tx_fire) begin
          if (is_wr) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
          end else begin
            state_d   = S_RESP_HI;
            tx_data_d = rdata_q[15:8];
          end
        end
      end
      S_RESP_HI: begin
        if (tx_fire) begin
          state_d   = S_RESP_LO;
          tx_data_d = rdata_q[7:0];
        end
      end
      S_RESP_LO: begin
        if (tx_fire) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
        end
      end
      S_RESP_ERR: begin
        if (tx_fire) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      op_q       <= 8'h00;
      id_q       <= 16'h0000;
      data_q     <= 16'h0000;
      rdata_q    <= 16'h0000;
      ena_q      <= 1'b0;
      wea_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      id_q       <= id_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      ena_q      <= ena_d;
      wea_q      <= wea_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_data  = tx_data_q;
  assign o_ena       = ena_q;
  assign o_wea       = wea_q;
  assign o_id        = id_q;
  assign o_data      = data_q;
  assign o_busy      = busy_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_debugger_value_initiator.sv
// Scoreboard bench for the debugger value initiator
// with a small value-bank model behind it.
module tb_debugger_value_initiator;
  import debugger_protocol_pkg::*;

  localparam int TO = 16;

  typedef struct {
    logic        wea;
    logic [15:0] id;
    logic [15:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        ena, wea, busy, overrun;
  logic [15:0] id, wdata, rdata;

  int errors = 0;
  int checks = 0;

  acc_t       acc_q[$];
  logic [7:0] tx_q[$];

  debugger_value_initiator_if tx_if();

  always #5 clk = ~clk;

  debugger_value_initiator #(
    .P_TIMEOUT_CYCLES(TO),
    .P_TIMEOUT_WIDTH (5)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_rx_valid(rx_valid),
    .i_rx_data (rx_data),
    .tx        (tx_if.master),
    .o_ena     (ena),
    .o_wea     (wea),
    .o_id      (id),
    .o_data    (wdata),
    .i_data    (rdata),
    .o_busy    (busy),
    .o_overrun (overrun)
  );

  // value bank model
  logic [15:0] bank_nes = 16'h0001;
  logic [15:0] bank_pool = 16'h0000;

  always @(posedge clk) begin
    if (ena && wea) begin
      if (id == VALUEID_NES_RESET_N)
        bank_nes <= wdata;
      else if (id == VALUEID_DEBUGGER_MEMORY_POOL)
        bank_pool <= wdata;
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (id == VALUEID_NES_RESET_N)
      rdata = bank_nes;
    else if (id == VALUEID_DEBUGGER_MEMORY_POOL)
      rdata = bank_pool;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: accesses and tx transfers vs scoreboard
  logic       stall = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("tx_hold_valid", {31'd0, tx_if.tx_valid}, 1);
        chk("tx_hold_data", {24'd0, tx_if.tx_data},
            {24'd0, stall_data});
      end
      if (ena) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_ena", {15'd0, wea, id}, 32'hFFFF_FFFF);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          chk("acc_wea", {31'd0, wea}, {31'd0, e.wea});
          chk("acc_id", {16'd0, id}, {16'd0, e.id});
          chk("acc_data", {16'd0, wdata}, {16'd0, e.data});
        end
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (tx_q.size() == 0) begin
          chk("unexpected_tx", {24'd0, tx_if.tx_data}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] b;
          b = tx_q.pop_front();
          chk("tx_byte", {24'd0, tx_if.tx_data}, {24'd0, b});
        end
      end
      stall = tx_if.tx_valid && !tx_if.tx_ready;
      stall_data = tx_if.tx_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_acc(input logic w,
                          input logic [15:0] i,
                          input logic [15:0] d);
    acc_t e;
    e.wea  = w;
    e.id   = i;
    e.data = d;
    acc_q.push_back(e);
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy && !tx_if.tx_valid &&
          tx_q.size() == 0 && acc_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick(1);
    end
    chk("drain", {31'd0, done}, 1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_ena", {31'd0, ena}, 0);
    chk("rst_wea", {31'd0, wea}, 0);
    chk("rst_txv", {31'd0, tx_if.tx_valid}, 0);
    chk("rst_txd", {24'd0, tx_if.tx_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ovr", {31'd0, overrun}, 0);
    chk("rst_id", {16'd0, id}, 0);
    chk("rst_data", {16'd0, wdata}, 0);
  endtask

  initial begin
    tx_if.tx_ready = 1'b1;
    tick(3);
    chk_reset_outs();
    rst = 1'b0;
    tick(2);

    // WRITE nes_reset_n = 0, with latency checks
    push_acc(1'b1, 16'h0001, 16'h0000);
    tx_q.push_back(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("lat_ena", {31'd0, ena}, 1);
    chk("lat_txv_early", {31'd0, tx_if.tx_valid}, 0);
    tick(1);
    chk("lat_txv", {31'd0, tx_if.tx_valid}, 1);
    wait_done();
    chk("nes_reset_n", {16'd0, bank_nes}, 0);

    // WRITE pool = 3, then READ it back
    push_acc(1'b1, 16'h0002, 16'h0003);
    tx_q.push_back(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h03);
    wait_done();
    push_acc(1'b0, 16'h0002, 16'h0003);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h03);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h02);
    wait_done();

    // READ unmapped id with tx backpressure
    tx_if.tx_ready = 1'b0;
    push_acc(1'b0, 16'h1234, 16'h0003);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    for (int i = 0; i < 10; i++) begin
      if (tx_if.tx_valid) break;
      tick(1);
    end
    chk("bp_valid", {31'd0, tx_if.tx_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_data", {24'd0, tx_if.tx_data}, 32'h02);
    end
    tx_if.tx_ready = 1'b1;
    wait_done();

    // unknown opcode
    tx_q.push_back(RESP_ERROR);
    send_byte(8'h7F);
    wait_done();

    // inter-byte timeout, then a normal READ
    send_byte(8'h01);
    send_byte(8'h00);
    tick(10);
    chk("to_not_yet", {31'd0, busy}, 1);
    tick(10);
    chk("to_idle", {31'd0, busy}, 0);
    push_acc(1'b0, 16'h0001, 16'h0003);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    wait_done();

    // byte during RESP_HI is dropped
    push_acc(1'b0, 16'h0002, 16'h0003);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h03);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h02);
    tick(2);
    send_byte(8'h55);
    chk("overrun", {31'd0, overrun}, 1);
    tick(1);
    chk("overrun_end", {31'd0, overrun}, 0);
    wait_done();

    // reset in DATA_LO abandons the command
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset_outs();
    tick(10);
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_nes", {16'd0, bank_nes}, 0);
    chk("post_rst_acc", acc_q.size(), 0);
    chk("post_rst_tx", tx_q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
